reset_sequencer: RTL

Releases NUM_STAGES downstream reset domains in order (PLL, memory controller, USB/UART bridge, user logic) after the board power-on reset pulse ends.
- Each stage leaves reset only after the previous stage acknowledges ready, plus a settle gap.
- Loss of a ready acknowledge re-runs the whole sequence.
- A stage that never becomes ready latches a fault.
- Driven by the power-on reset output of the system reset generator; sits at the top level in front of all functional blocks.

---
 rtl/reset_seq_pkg.sv | 27 ++
 rtl/reset_sequencer_seq_timer.sv | 22 ++
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the ordered reset-release sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ASSERT   = 3'd0,
    WAIT_ACK = 3'd1,
    GAP      = 3'd2,
    RUN      = 3'd3,
    FLT      = 3'd4
  } state_t;

  localparam int unsigned IDX_W = 4;

  // Counter must hold max(HOLD,DELAY,TIMEOUT)-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned delay,
                                            input int unsigned timeout);
    int unsigned m;
    int unsigned w;
    m = hold;
    if (delay > m) m = delay;
    if (timeout > m) m = timeout;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Shared up-counter for hold, settle-gap and ack-timeout intervals.
module seq_timer #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign at_term = (cnt == term);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order, each gated on the previous
// stage's ack plus a settle gap; ack loss restarts, a missing ack faults.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned HOLD       = 16,
  parameter int unsigned DELAY      = 256,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SW_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_ACK,
  output logic [NUM_STAGES-1:0] RST_OUT,
  output logic                  ALL_READY,
  output logic                  FAULT,
  output logic [IDX_W-1:0]      STAGE_IDX
);

  localparam int unsigned CW = cnt_width(HOLD, DELAY, TIMEOUT);
  localparam logic [CW-1:0] HOLD_T    = CW'(HOLD - 1);
  localparam logic [CW-1:0] DELAY_T   = CW'(DELAY - 1);
  localparam logic [CW-1:0] TIMEOUT_T = CW'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(NUM_STAGES - 1);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [NUM_STAGES-1:0]   rst_out_nxt;
  logic                    all_ready_nxt, fault_nxt;
  logic                    t_clr, t_en, at_term;
  logic [CW-1:0]           t_term, cnt;
  logic                    ack_cur, ack_lost;

  seq_timer #(.W(CW)) u_timer (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (t_clr),
    .en      (t_en),
    .term    (t_term),
    .cnt     (cnt),
    .at_term (at_term)
  );

  always_comb begin
    case (state)
      ASSERT:   t_term = HOLD_T;
      WAIT_ACK: t_term = TIMEOUT_T;
      GAP:      t_term = DELAY_T;
      default:  t_term = '0;
    endcase
  end

  // Acknowledged stages are those below idx while waiting, up to idx afterwards.
  always_comb begin
    ack_cur  = 1'b0;
    ack_lost = 1'b0;
    for (int unsigned j = 0; j < NUM_STAGES; j++) begin
      if (IDX_W'(j) == idx) ack_cur = STAGE_ACK[j];
      if (!STAGE_ACK[j]) begin
        if (state == WAIT_ACK && IDX_W'(j) < idx) ack_lost = 1'b1;
        if ((state == GAP || state == RUN) && IDX_W'(j) <= idx) ack_lost = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ASSERT;
      idx       <= '0;
      RST_OUT   <= '1;
      ALL_READY <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      RST_OUT   <= rst_out_nxt;
      ALL_READY <= all_ready_nxt;
      FAULT     <= fault_nxt;
    end
  end

  // A late ack on the timeout cycle still counts, so ack is tested before timeout.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    t_clr     = 1'b0;
    t_en      = 1'b0;
    if (SW_RST_REQ || ack_lost) begin
      state_nxt = ASSERT;
      idx_nxt   = '0;
      t_clr     = 1'b1;
    end else begin
      case (state)
        ASSERT: begin
          if (at_term) begin
            state_nxt = WAIT_ACK;
            idx_nxt   = '0;
            t_clr     = 1'b1;
          end else begin
            t_en = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_cur) begin
            state_nxt = (idx == LAST) ? RUN : GAP;
            t_clr     = 1'b1;
          end else if (at_term) begin
            state_nxt = FLT;
            t_clr     = 1'b1;
          end else begin
            t_en = 1'b1;
          end
        end
        GAP: begin
          if (at_term) begin
            state_nxt = WAIT_ACK;
            idx_nxt   = idx + IDX_W'(1);
            t_clr     = 1'b1;
          end else begin
            t_en = 1'b1;
          end
        end
        RUN, FLT: ;
        default: begin
          state_nxt = ASSERT;
          idx_nxt   = '0;
          t_clr     = 1'b1;
        end
      endcase
    end
  end

  // Released stages are exactly 0..idx whenever the sequence is live.
  always_comb begin
    rst_out_nxt   = '1;
    all_ready_nxt = (state_nxt == RUN);
    fault_nxt     = FAULT;
    if (state_nxt == WAIT_ACK || state_nxt == GAP || state_nxt == RUN) begin
      for (int unsigned j = 0; j < NUM_STAGES; j++) begin
        if (IDX_W'(j) <= idx_nxt) rst_out_nxt[j] = 1'b0;
      end
    end
    if (SW_RST_REQ)              fault_nxt = 1'b0;
    else if (state_nxt == FLT)   fault_nxt = 1'b1;
  end

  assign STAGE_IDX = idx;

endmodule
